// File: rtl/rx_module.sv
// rx_module: serial frame receiver for a 1-bit-per-clock link.
// Frame format: start(0), DATA_WIDTH data bits, even parity, stop(1).
// The received word is held under a valid/ack handshake. Parity, framing and
// overrun errors are reported alongside it.
// Optional feature macro: RX_PARITY_CHECK_EN. When it is defined, the parity bit
// is checked and parity_err is driven. When it is undefined, the parity bit is
// still consumed so the frame length does not change, and parity_err is tied 0.
//
// Handshake: data_valid rises the cycle after a good stop bit and stays high
// until a cycle in which data_ack=1 and data_valid=1. data_out and parity_err
// are stable while data_valid=1. data_ack while data_valid=0 is ignored. If a
// frame completes in the same cycle as the ack, the new word wins and
// data_valid stays high.
module rx_module #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  rx,
   input  logic                  data_ack,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  overrun_err,
   output logic                  busy,
   output logic [2:0]            state_dbg
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] DATA      = 3'd1;
   localparam logic [2:0] PARITY    = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   localparam int              CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

   logic [2:0]            state;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;

`ifdef RX_PARITY_CHECK_EN
   logic running;
   logic perr;
   logic parity_q;
`endif

   // Receive FSM, word capture, handshake and error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
         running     <= 1'b0;
         perr        <= 1'b0;
         parity_q    <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         // The consumer ack is applied first, so a completing frame below
         // can still override it in the same cycle.
         if (data_ack && data_valid) begin
            data_valid  <= 1'b0;
            overrun_err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (enable && !rx) begin
                  state   <= DATA;
                  bit_cnt <= '0;
`ifdef RX_PARITY_CHECK_EN
                  running <= 1'b0;
`endif
               end
            end
            DATA: begin
               if (MSB_FIRST)
                  shift_reg <= {shift_reg[DATA_WIDTH-2:0], rx};
               else
                  shift_reg <= {rx, shift_reg[DATA_WIDTH-1:1]};
`ifdef RX_PARITY_CHECK_EN
               running <= running ^ rx;
`endif
               if (bit_cnt == LAST_BIT)
                  state <= PARITY;
               else
                  bit_cnt <= bit_cnt + CW'(1);
            end
            PARITY: begin
`ifdef RX_PARITY_CHECK_EN
               perr <= running ^ rx;
`endif
               state <= STOP;
            end
            STOP: begin
               if (rx) begin
                  data_out   <= shift_reg;
                  data_valid <= 1'b1;
`ifdef RX_PARITY_CHECK_EN
                  parity_q   <= perr;
`endif
                  // An unconsumed word is being overwritten.
                  if (data_valid && !data_ack)
                     overrun_err <= 1'b1;
                  state <= IDLE;
               end else begin
                  frame_err <= 1'b1;
                  state     <= WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               // Do not treat a stuck-low line as a run of start bits.
               if (rx)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RX_PARITY_CHECK_EN
   assign parity_err = parity_q;
`else
   assign parity_err = 1'b0;
`endif

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_rx_module.sv
// Directed testbench for rx_module (DATA_WIDTH=8, MSB_FIRST=1).
module tb_rx_module;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       rx;
   logic       data_ack;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;
   logic [2:0] state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   int bc;

`ifdef RX_PARITY_CHECK_EN
   localparam logic EXP_BAD_PERR = 1'b1;
`else
   localparam logic EXP_BAD_PERR = 1'b0;
`endif

   rx_module #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .rx(rx), .data_ack(data_ack),
      .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
      .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy),
      .state_dbg(state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
         $error("check %s failed", tag);
      end
   endtask

   task automatic ack();
      data_ack = 1'b1;
      step();
      data_ack = 1'b0;
   endtask

   // Drives one full frame MSB first. Returns how many post-edge samples had busy=1.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input logic drop_en, input logic ack_at_stop,
                             output int busy_cnt);
      busy_cnt = 0;
      rx = 1'b0;
      step();
      if (drop_en) enable = 1'b0;
      if (busy) busy_cnt++;
      for (int i = 7; i >= 0; i--) begin
         rx = d[i];
         step();
         if (busy) busy_cnt++;
      end
      rx = par;
      step();
      if (busy) busy_cnt++;
      rx = stop;
      data_ack = ack_at_stop;
      step();
      data_ack = 1'b0;
      if (busy) busy_cnt++;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; rx = 1'b1; data_ack = 1'b0;
      step(); step();
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_valid", 32'(data_valid), 32'h0);
      chk("rst_perr", 32'(parity_err), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_ovr", 32'(overrun_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      enable = 1'b1;
      step();

      // 1: 0xA5, good parity
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, bc);
      chk("t1_busy_cycles", 32'(bc), 32'd10);
      chk("t1_data", 32'(data_out), 32'hA5);
      chk("t1_valid", 32'(data_valid), 32'h1);
      chk("t1_perr", 32'(parity_err), 32'h0);
      chk("t1_busy_after", 32'(busy), 32'h0);
      step();
      chk("t1_valid_held", 32'(data_valid), 32'h1);
      ack();
      chk("t1_ack_clears", 32'(data_valid), 32'h0);

      // 2: 0xA5, wrong parity bit
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, bc);
      chk("t2_data", 32'(data_out), 32'hA5);
      chk("t2_valid", 32'(data_valid), 32'h1);
      chk("t2_perr", 32'(parity_err), 32'(EXP_BAD_PERR));
      ack();
      chk("t2_ack_clears", 32'(data_valid), 32'h0);

      // 3: 0x3C with stop bit 0, line held low 5 cycles total
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, bc);
      chk("t3_ferr_pulse", 32'(frame_err), 32'h1);
      chk("t3_valid", 32'(data_valid), 32'h0);
      rx = 1'b0;
      step();
      chk("t3_ferr_one_cycle", 32'(frame_err), 32'h0);
      chk("t3_wait_busy", 32'(busy), 32'h1);
      step(); step(); step();
      chk("t3_still_waiting", 32'(state_dbg), 32'd4);
      chk("t3_valid_low", 32'(data_valid), 32'h0);
      rx = 1'b1;
      step();
      chk("t3_idle", 32'(busy), 32'h0);
      chk("t3_data_kept", 32'(data_out), 32'hA5);

      // 4: overrun, 0x11 then 0x22 back to back
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, bc);
      chk("t4_first_valid", 32'(data_valid), 32'h1);
      chk("t4_first_no_ovr", 32'(overrun_err), 32'h0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, bc);
      chk("t4_data", 32'(data_out), 32'h22);
      chk("t4_ovr", 32'(overrun_err), 32'h1);
      chk("t4_valid", 32'(data_valid), 32'h1);
      ack();
      chk("t4_ack_valid", 32'(data_valid), 32'h0);
      chk("t4_ack_ovr", 32'(overrun_err), 32'h0);

      // 5: reset at data bit 4 of 0x5A, then a clean 0x5A
      rx = 1'b0; step();
      rx = 1'b0; step();
      rx = 1'b1; step();
      rx = 1'b0; step();
      reset = 1'b1; rx = 1'b1; step();
      chk("t5_rst_data", 32'(data_out), 32'h0);
      chk("t5_rst_busy", 32'(busy), 32'h0);
      chk("t5_rst_state", 32'(state_dbg), 32'd0);
      chk("t5_rst_flags", 32'({data_valid, parity_err, frame_err, overrun_err}), 32'h0);
      reset = 1'b0; rx = 1'b1;
      step();
      chk("t5_idle_after", 32'(busy), 32'h0);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, bc);
      chk("t5_data", 32'(data_out), 32'h5A);
      chk("t5_valid", 32'(data_valid), 32'h1);
      chk("t5_perr", 32'(parity_err), 32'h0);
      ack();

      // 6: enable=0 ignores low pulses; dropping enable mid-frame still completes
      enable = 1'b0;
      rx = 1'b0;
      bc = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (busy) bc++;
      end
      chk("t6_disabled_busy", 32'(bc), 32'd0);
      rx = 1'b1;
      step();
      chk("t6_no_flags", 32'({data_valid, frame_err, overrun_err}), 32'h0);
      enable = 1'b1;
      send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, bc);
      chk("t6_drop_busy_cycles", 32'(bc), 32'd10);
      chk("t6_drop_data", 32'(data_out), 32'hC3);
      chk("t6_drop_valid", 32'(data_valid), 32'h1);
      enable = 1'b1;

      // 7: completion and ack in the same cycle
      send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, bc);
      chk("t7_data", 32'(data_out), 32'h0F);
      chk("t7_valid_stays", 32'(data_valid), 32'h1);
      chk("t7_no_ovr", 32'(overrun_err), 32'h0);
      ack();
      chk("t7_ack_clears", 32'(data_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
